// File: rtl/syn_fifo_wr_arb.sv
// Round-robin arbiter sharing one syn_fifo write port among NREQ producers, bounded bursts.
// Optional macro SYN_FIFO_WR_ARB_PRIO0_EN: port 0 wins every IDLE arbitration it requests.
module syn_fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic [NREQ-1:0]        I_req,
  input  logic [NREQ*DSIZE-1:0]  I_data,
  output logic [NREQ-1:0]        O_ack,
  output logic                   O_winc,
  output logic [DSIZE-1:0]       O_wdata,
  input  logic                   I_wfull,
  output logic                   O_busy,
  output logic [GW-1:0]          O_gnt_id
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              r_state, w_state_nxt;
  logic [GW-1:0]       r_gnt, r_last, w_sel;
  logic [7:0]          r_beats;
  logic [2*NREQ-1:0]   w_rot;
  logic [31:0]         w_off, w_port;
  logic                w_req_gnt, w_winc, w_end, w_busy;
  logic [DSIZE-1:0]    w_data_gnt;

  // Rotate requests so bit 0 is port last+1; the lowest set bit is the round-robin winner.
  always_comb begin
    w_rot  = {I_req, I_req} >> (32'(r_last) + 32'd1);
    w_off  = '0;
    for (int unsigned j = NREQ; j > 0; j--) begin
      if (w_rot[j-1]) w_off = 32'(j - 1);
    end
    w_port = 32'(r_last) + 32'd1 + w_off;
    if (w_port >= 32'(NREQ)) w_port = w_port - 32'(NREQ);
    w_sel  = GW'(w_port);
`ifdef SYN_FIFO_WR_ARB_PRIO0_EN
    if (I_req[0]) w_sel = '0;
`endif
  end

  always_comb begin
    w_req_gnt  = 1'b0;
    w_data_gnt = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (r_gnt == GW'(k)) begin
        w_req_gnt  = I_req[k];
        w_data_gnt = I_data[k*DSIZE +: DSIZE];
      end
    end
  end

  always_comb begin
    w_busy      = (r_state == S_BURST);
    w_winc      = w_busy & w_req_gnt & ~I_wfull;
    // A stall (full) never ends a burst; only a counted last beat or an idle requester does.
    w_end       = w_busy & ((w_winc & (r_beats == 8'(BURST - 1))) | (~w_req_gnt & ~I_wfull));
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|I_req) w_state_nxt = S_BURST;
      S_BURST: if (w_end)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    O_winc = w_winc;
    for (int unsigned k = 0; k < NREQ; k++) begin
      O_ack[k] = w_winc & (r_gnt == GW'(k));
    end
    O_wdata  = w_busy ? w_data_gnt : '0;
    O_busy   = w_busy;
    O_gnt_id = r_gnt;
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_last  <= GW'(NREQ - 1);
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && |I_req) begin
        r_gnt   <= w_sel;
        r_beats <= '0;
      end else if (w_winc) begin
        r_beats <= r_beats + 8'd1;
      end
      if (w_end) r_last <= r_gnt;
    end
  end

endmodule

// File: tb/tb_syn_fifo_wr_arb.sv
// Directed bench for syn_fifo_wr_arb (NREQ=4, DSIZE=8, BURST=4) with a write scoreboard.
// Honours SYN_FIFO_WR_ARB_PRIO0_EN when the bench is built with it.
module tb_syn_fifo_wr_arb;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic [3:0]  I_req;
  logic [31:0] I_data;
  logic [3:0]  O_ack;
  logic        O_winc;
  logic [7:0]  O_wdata;
  logic        I_wfull;
  logic        O_busy;
  logic [1:0]  O_gnt_id;

  syn_fifo_wr_arb #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_req(I_req), .I_data(I_data),
    .O_ack(O_ack), .O_winc(O_winc), .O_wdata(O_wdata), .I_wfull(I_wfull),
    .O_busy(O_busy), .O_gnt_id(O_gnt_id)
  );

  always #5 I_clk = ~I_clk;

  typedef struct packed { logic [1:0] port; logic [7:0] data; } beat_t;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  pmem [4][64];
  int          phead [4];
  int          ptail [4];
  int          ecnt  [4];
  beat_t       exp_q [$];
  logic [7:0]  ref_q [$];
  logic [7:0]  fq    [$];
  int          fcount, nwinc;
  logic        fifo_mode, force_full;
  logic        ob_busy, ob_winc;
  logic [3:0]  ob_ack;
  logic [1:0]  ob_gnt;
  logic [7:0]  ob_wdata;
  int          gseq [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int k, input int n);
    for (int j = 0; j < n; j++) begin
      pmem[k][ptail[k]] = 8'(k*64 + ptail[k]);
      ptail[k]++;
    end
  endtask

  task automatic expect_beats(input int k, input int n);
    beat_t e;
    for (int j = 0; j < n; j++) begin
      e.port = 2'(k);
      e.data = 8'(k*64 + ecnt[k]);
      ecnt[k]++;
      exp_q.push_back(e);
      ref_q.push_back(e.data);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, retire accepted beats at posedge.
  task automatic cycle();
    beat_t e;
    for (int k = 0; k < 4; k++) begin
      I_req[k]        = (phead[k] != ptail[k]);
      I_data[k*8 +: 8] = (phead[k] != ptail[k]) ? pmem[k][phead[k]] : 8'h00;
    end
    I_wfull = fifo_mode ? (fcount >= 16) : force_full;
    #1;
    ob_busy = O_busy; ob_winc = O_winc; ob_ack = O_ack; ob_gnt = O_gnt_id; ob_wdata = O_wdata;
    if (I_wfull) chk("winc_while_full", 32'(ob_winc), 32'd0);
    if (ob_winc) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ack_port", 32'(ob_ack), 32'd1 << e.port);
        chk("wdata", 32'(ob_wdata), 32'(e.data));
        chk("gnt_id", 32'(ob_gnt), 32'(e.port));
      end
    end else begin
      chk("ack_without_winc", 32'(ob_ack), 32'd0);
    end
    @(posedge I_clk);
    if (ob_winc) begin
      nwinc++;
      for (int k = 0; k < 4; k++) if (ob_ack[k]) phead[k]++;
      if (fifo_mode) begin
        fcount++;
        fq.push_back(ob_wdata);
      end
    end
    @(negedge I_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Leaves I_req as last driven so a reset can land on a live burst.
  task automatic do_reset();
    I_rst_n = 1'b0;
    I_wfull = 1'b0;
    @(posedge I_clk); #1;
    chk("rst_busy",  32'(O_busy),   32'd0);
    chk("rst_winc",  32'(O_winc),   32'd0);
    chk("rst_ack",   32'(O_ack),    32'd0);
    chk("rst_wdata", 32'(O_wdata),  32'd0);
    chk("rst_gnt",   32'(O_gnt_id), 32'd0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin phead[k] = 0; ptail[k] = 0; ecnt[k] = 0; end
    exp_q.delete(); ref_q.delete(); fq.delete();
    fcount = 0; nwinc = 0; fifo_mode = 1'b0; force_full = 1'b0;
  endtask

  initial begin
    I_rst_n = 1'b0; I_req = '0; I_data = '0; I_wfull = 1'b0;
    fifo_mode = 1'b0; force_full = 1'b0; fcount = 0; nwinc = 0;
    @(negedge I_clk);
    do_reset();

    // 1: all four ports busy, two full rounds of 4-beat bursts plus one bubble each.
`ifdef SYN_FIFO_WR_ARB_PRIO0_EN
    gseq = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    gseq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int k = 0; k < 4; k++) load(k, 8);
    for (int b = 0; b < 8; b++) expect_beats(gseq[b], 4);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (i % 5 == 0) chk("t1_bubble", 32'(ob_busy), 32'd0);
      else begin
        chk("t1_busy", 32'(ob_busy), 32'd1);
        chk("t1_winc", 32'(ob_winc), 32'd1);
        chk("t1_gnt",  32'(ob_gnt),  32'(gseq[i/5]));
      end
    end
    chk("t1_left", 32'(exp_q.size()), 32'd0);

    // 2: port 2 alone for two beats, then drops; next round starts after port 2.
    do_reset();
    load(2, 2); expect_beats(2, 2);
    cycle(); chk("t2_idle", 32'(ob_busy), 32'd0);
    run(2);
    cycle(); chk("t2_tail_busy", 32'(ob_busy), 32'd1);
    chk("t2_tail_winc", 32'(ob_winc), 32'd0);
    cycle(); chk("t2_fall", 32'(ob_busy), 32'd0);
    chk("t2_last_gnt", 32'(ob_gnt), 32'd2);
    chk("t2_beats", 32'(nwinc), 32'd2);
    for (int k = 0; k < 4; k++) load(k, 1);
`ifdef SYN_FIFO_WR_ARB_PRIO0_EN
    expect_beats(0, 1); expect_beats(1, 1); expect_beats(2, 1); expect_beats(3, 1);
`else
    expect_beats(3, 1); expect_beats(0, 1); expect_beats(1, 1); expect_beats(2, 1);
`endif
    run(14);
    chk("t2_left", 32'(exp_q.size()), 32'd0);

    // 3: stall mid-burst for three cycles; the burst still totals four beats.
    do_reset();
    load(1, 6); expect_beats(1, 6);
    run(3);
    force_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_stall_winc", 32'(ob_winc), 32'd0);
      chk("t3_stall_busy", 32'(ob_busy), 32'd1);
    end
    force_full = 1'b0;
    run(2);
    chk("t3_beats4", 32'(nwinc), 32'd4);
    cycle(); chk("t3_end_by_count", 32'(ob_busy), 32'd0);
    run(5);
    chk("t3_total", 32'(nwinc), 32'd6);
    chk("t3_left", 32'(exp_q.size()), 32'd0);

    // 4: two ports fill a 16-deep FIFO nobody drains.
    do_reset();
    fifo_mode = 1'b1;
    load(0, 12); load(1, 12);
`ifdef SYN_FIFO_WR_ARB_PRIO0_EN
    expect_beats(0, 12); expect_beats(1, 4);
`else
    expect_beats(0, 4); expect_beats(1, 4); expect_beats(0, 4); expect_beats(1, 4);
`endif
    run(40);
    chk("t4_winc_count", 32'(nwinc), 32'd16);
    chk("t4_stalled_busy", 32'(ob_busy), 32'd1);
    chk("t4_fifo_depth", 32'(fq.size()), 32'd16);
    for (int i = 0; i < 16 && fq.size() > 0 && ref_q.size() > 0; i++)
      chk("t4_readback", 32'(fq.pop_front()), 32'(ref_q.pop_front()));

    // 5: reset lands in a port-1 burst; afterwards port 0 is granted first.
    do_reset();
    load(1, 8); expect_beats(1, 2);
    run(3);
    chk("t5_in_burst", 32'(ob_gnt), 32'd1);
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 1);
    expect_beats(0, 1); expect_beats(1, 1); expect_beats(2, 1); expect_beats(3, 1);
    cycle(); chk("t5_idle", 32'(ob_busy), 32'd0);
    cycle(); chk("t5_first_gnt", 32'(ob_gnt), 32'd0);
    chk("t5_first_winc", 32'(ob_winc), 32'd1);
    run(12);
    chk("t5_left", 32'(exp_q.size()), 32'd0);

    // 6: ports 0 and 3 both continuous.
    do_reset();
    load(0, 8); load(3, 8);
`ifdef SYN_FIFO_WR_ARB_PRIO0_EN
    expect_beats(0, 8); expect_beats(3, 8);
`else
    expect_beats(0, 4); expect_beats(3, 4); expect_beats(0, 4); expect_beats(3, 4);
`endif
    run(22);
    chk("t6_left", 32'(exp_q.size()), 32'd0);
    chk("t6_beats", 32'(nwinc), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
